// File: rtl/image_loader_pkg.sv
// image_loader_pkg
// Shared constants, word-count helper and FSM state type for the image loader.
// Default geometry: 784 binary pixels carried in 32-bit words (25 words),
// 1024 network evaluation cycles per image.
package image_loader_pkg;

    localparam int NUM_PIXELS_DEF = 784;
    localparam int WORD_W_DEF     = 32;
    localparam int RUN_CYCLES_DEF = 1024;
    localparam int IDX_W          = 5;

    function automatic int nwords(input int num_pixels, input int word_w);
        return (num_pixels + word_w - 1) / word_w;
    endfunction

    localparam int NWORDS = nwords(NUM_PIXELS_DEF, WORD_W_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/image_buf.sv
// image_buf
// Word-addressed assembly register for one image.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset (clears the image)
//   we_i            write word word_i at word index idx_i
//   idx_i           word index
//   word_i          word data; only the low bits of the final word are kept
//   img_o           assembled image
module image_buf
    import image_loader_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int WORD_W     = WORD_W_DEF,
    parameter int NW         = nwords(NUM_PIXELS, WORD_W)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [WORD_W-1:0]     word_i,
    output logic [NUM_PIXELS-1:0] img_o
);

    for (genvar k = 0; k < NW; k++) begin : g_word
        localparam int LO = k * WORD_W;
        // The final word only covers what is left of the image.
        localparam int W  = (k == NW - 1) ? (NUM_PIXELS - LO) : WORD_W;

        logic [W-1:0] word_q;

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                word_q <= '0;
            end else if (we_i && (idx_i == IDX_W'(k))) begin
                word_q <= word_i[W-1:0];
            end
        end

        assign img_o[LO +: W] = word_q;
    end

endmodule

// File: rtl/image_loader.sv
// image_loader
// Assembles a binary image from host words, presents it to the spiking network,
// times the evaluation run and captures the two-bit classification.
// Ports:
//   iCLK, iRESETn          clock, asynchronous active-low reset
//   iWORD, iVALID, oREADY  word stream from the host bridge (valid/ready)
//   iABORT                 discard a partial image or an in-flight run
//   oPIXELS, oSTART        image and one-cycle start pulse to the network
//   iSNN_OUT               network neuron outputs
//   oRESULT, oRESULT_VALID captured classification and its one-cycle strobe
//   oBUSY                  high in START, RUN and DONE
//   oWORD_IDX              index of the next word expected
// Build option: IMAGE_LOADER_DBLBUF_EN keeps the word stream open during a run
// so the next image assembles while the current one is evaluated.
//
// state  | meaning
// IDLE   | no image in progress, waiting for word 0
// LOAD   | collecting words 1..NWORDS-1
// START  | image latched on oPIXELS, oSTART high this cycle
// RUN    | evaluation timer counting down
// DONE   | result captured, oRESULT_VALID high this cycle
module image_loader
    import image_loader_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int WORD_W     = WORD_W_DEF,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRESETn,
    input  logic [WORD_W-1:0]     iWORD,
    input  logic                  iVALID,
    output logic                  oREADY,
    input  logic                  iABORT,
    output logic [NUM_PIXELS-1:0] oPIXELS,
    output logic                  oSTART,
    input  logic [1:0]            iSNN_OUT,
    output logic [1:0]            oRESULT,
    output logic                  oRESULT_VALID,
    output logic                  oBUSY,
    output logic [IDX_W-1:0]      oWORD_IDX
);

    localparam int NW      = nwords(NUM_PIXELS, WORD_W);
    localparam int LAST_LO = (NW - 1) * WORD_W;
    localparam int LAST_W  = NUM_PIXELS - LAST_LO;
    localparam int CNT_W   = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_PIXELS-1:0]   pixels_q;
    logic                    start_q;
    logic [1:0]              result_q;
    logic                    rvalid_q;
    logic                    pending_q;   // complete next image waiting in the buffer

    logic                    in_load;
    logic                    xfer;
    logic                    last_xfer;
    logic                    buf_we;
    logic [IDX_W-1:0]        idx_d;
    logic [NUM_PIXELS-1:0]   buf_img;
    logic [NUM_PIXELS-1:0]   img_full_d;

    assign in_load = (state_q == ST_IDLE) || (state_q == ST_LOAD);

`ifdef IMAGE_LOADER_DBLBUF_EN
    assign oREADY = in_load || !pending_q;
`else
    assign oREADY = in_load;
`endif

    assign xfer      = iVALID && oREADY;
    assign last_xfer = xfer && (idx_q == LAST_IDX);
    // Abort in LOAD wins over a simultaneous transfer.
    assign buf_we    = xfer && !((state_q == ST_LOAD) && iABORT);
    assign idx_d     = last_xfer ? '0 : (xfer ? idx_q + 1'b1 : idx_q);

    image_buf #(
        .NUM_PIXELS (NUM_PIXELS),
        .WORD_W     (WORD_W),
        .NW         (NW)
    ) u_buf (
        .clk_i   (iCLK),
        .rst_n_i (iRESETn),
        .we_i    (buf_we),
        .idx_i   (idx_q),
        .word_i  (iWORD),
        .img_o   (buf_img)
    );

    // The final word lands in the buffer on the same edge that latches
    // oPIXELS, so merge it in directly.
    always_comb begin
        img_full_d = buf_img;
        if (last_xfer) begin
            img_full_d[NUM_PIXELS-1:LAST_LO] = iWORD[LAST_W-1:0];
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pixels_q  <= '0;
            start_q   <= 1'b0;
            result_q  <= '0;
            rvalid_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            start_q  <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    if ((state_q == ST_LOAD) && iABORT) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                    end else if (xfer) begin
                        idx_q <= idx_d;
                        if (last_xfer) begin
                            state_q  <= ST_START;
                            start_q  <= 1'b1;
                            pixels_q <= img_full_d;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_START, ST_RUN, ST_DONE: begin
                    // Only reachable with transfers when the stream stays open.
                    idx_q <= idx_d;
                    if ((state_q == ST_DONE) || iABORT) begin
                        if (pending_q || last_xfer) begin
                            state_q   <= ST_START;
                            start_q   <= 1'b1;
                            pixels_q  <= img_full_d;
                            pending_q <= 1'b0;
                        end else begin
                            state_q <= (idx_d != '0) ? ST_LOAD : ST_IDLE;
                        end
                    end else begin
                        if (last_xfer) begin
                            pending_q <= 1'b1;
                        end
                        if (state_q == ST_START) begin
                            state_q <= ST_RUN;
                            cnt_q   <= CNT_W'(RUN_CYCLES - 1);
                        end else if (cnt_q == '0) begin
                            state_q  <= ST_DONE;
                            result_q <= iSNN_OUT;
                            rvalid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oPIXELS       = pixels_q;
    assign oSTART        = start_q;
    assign oRESULT       = result_q;
    assign oRESULT_VALID = rvalid_q;
    assign oBUSY         = !in_load;
    assign oWORD_IDX     = idx_q;

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;

`ifdef IMAGE_LOADER_DBLBUF_EN
    localparam int RUNC = 40;
`else
    localparam int RUNC = 8;
`endif

    logic         iCLK;
    logic         iRESETn;
    logic [31:0]  iWORD;
    logic         iVALID;
    logic         oREADY;
    logic         iABORT;
    logic [783:0] oPIXELS;
    logic         oSTART;
    logic [1:0]   iSNN_OUT;
    logic [1:0]   oRESULT;
    logic         oRESULT_VALID;
    logic         oBUSY;
    logic [4:0]   oWORD_IDX;

    int n_chk = 0;
    int n_err = 0;
    int start_cnt = 0;
    int rv_cnt = 0;

    image_loader #(
        .NUM_PIXELS (784),
        .WORD_W     (32),
        .RUN_CYCLES (RUNC)
    ) dut (
        .iCLK          (iCLK),
        .iRESETn       (iRESETn),
        .iWORD         (iWORD),
        .iVALID        (iVALID),
        .oREADY        (oREADY),
        .iABORT        (iABORT),
        .oPIXELS       (oPIXELS),
        .oSTART        (oSTART),
        .iSNN_OUT      (iSNN_OUT),
        .oRESULT       (oRESULT),
        .oRESULT_VALID (oRESULT_VALID),
        .oBUSY         (oBUSY),
        .oWORD_IDX     (oWORD_IDX)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) begin
        if (oSTART)        start_cnt++;
        if (oRESULT_VALID) rv_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [799:0] got, input logic [799:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int pat, input int k);
        case (pat)
            0:       return 32'hFFFF_FFFF;
            1:       return 32'(k);
            default: return 32'h1000_0000 | 32'(k);
        endcase
    endfunction

    // Word k occupies bits 32k+31:32k; word 24 keeps only its low 16 bits.
    function automatic logic [783:0] img_exp(input int pat);
        logic [799:0] v;
        v = '0;
        for (int k = 0; k < 25; k++) v[32*k +: 32] = word_of(pat, k);
        return v[783:0];
    endfunction

    task automatic send_word(input logic [31:0] w);
        iVALID = 1'b1;
        iWORD  = w;
        tick();
        iVALID = 1'b0;
    endtask

    task automatic send_img(input int pat, input bit gaps);
        for (int k = 0; k < 25; k++) begin
            if (gaps) begin
                iVALID = 1'b0;
                tick();
                chk("idx_hold", 800'(oWORD_IDX), 800'(k));
            end
            send_word(word_of(pat, k));
            if (k == 0) chk("idx_first", 800'(oWORD_IDX), 800'd1);
        end
    endtask

    // Called at the START cycle; follows the run back to IDLE.
    task automatic run_check(input logic [1:0] er);
        int n;
        int bad;
        int rv0;
        logic [1:0] r;
        n = -1; bad = 0; rv0 = rv_cnt; r = 2'b00;
        for (int i = 1; i <= RUNC + 12; i++) begin
            tick();
            if (oRESULT_VALID && n < 0) begin
                n = i;
                r = oRESULT;
            end
`ifndef IMAGE_LOADER_DBLBUF_EN
            if (oBUSY && oREADY) bad++;
`endif
        end
        chk("res_lat", 800'(n), 800'(RUNC + 1));
        chk("result", 800'(r), 800'(er));
        chk("rv_pulses", 800'(rv_cnt - rv0), 800'd1);
        chk("res_hold", 800'(oRESULT), 800'(er));
`ifndef IMAGE_LOADER_DBLBUF_EN
        chk("rdy_in_run", 800'(bad), 800'd0);
`endif
        chk("end_busy", 800'(oBUSY), 800'd0);
        chk("end_rdy", 800'(oREADY), 800'd1);
    endtask

    initial begin
        int s0;
        iRESETn  = 1'b0;
        iWORD    = '0;
        iVALID   = 1'b0;
        iABORT   = 1'b0;
        iSNN_OUT = 2'b10;

        // Reset state
        repeat (2) tick();
        chk("rst_pix", 800'(oPIXELS), 800'd0);
        chk("rst_idx", 800'(oWORD_IDX), 800'd0);
        chk("rst_start", 800'(oSTART), 800'd0);
        chk("rst_res", 800'(oRESULT), 800'd0);
        chk("rst_rv", 800'(oRESULT_VALID), 800'd0);
        chk("rst_busy", 800'(oBUSY), 800'd0);
        iRESETn = 1'b1;
        tick();
        chk("rel_rdy", 800'(oREADY), 800'd1);

        // All-ones image, back to back
        s0 = start_cnt;
        send_img(0, 1'b0);
        chk("t1_start", 800'(oSTART), 800'd1);
        chk("t1_idx", 800'(oWORD_IDX), 800'd0);
        chk("t1_busy", 800'(oBUSY), 800'd1);
        chk("t1_pix", 800'(oPIXELS), 800'({784{1'b1}}));
`ifdef IMAGE_LOADER_DBLBUF_EN
        chk("t1_rdy", 800'(oREADY), 800'd1);
`else
        chk("t1_rdy", 800'(oREADY), 800'd0);
`endif
        run_check(2'b10);
        chk("t1_nstart", 800'(start_cnt - s0), 800'd1);

        // Word k = k with gaps between words
        s0 = start_cnt;
        send_img(1, 1'b1);
        chk("t2_start", 800'(oSTART), 800'd1);
        chk("t2_pix", 800'(oPIXELS), 800'(img_exp(1)));
        chk("t2_w5", 800'(oPIXELS[191:160]), 800'd5);
        chk("t2_w24", 800'(oPIXELS[783:768]), 800'd24);
        run_check(2'b10);
        chk("t2_nstart", 800'(start_cnt - s0), 800'd1);
        chk("t2_pixhold", 800'(oPIXELS), 800'(img_exp(1)));

        // Abort together with word 10
        for (int k = 0; k < 10; k++) send_word(word_of(2, k));
        chk("t3_idx10", 800'(oWORD_IDX), 800'd10);
        iABORT = 1'b1;
        send_word(word_of(2, 10));
        iABORT = 1'b0;
        chk("t3_idx0", 800'(oWORD_IDX), 800'd0);
        chk("t3_busy", 800'(oBUSY), 800'd0);
        chk("t3_pix", 800'(oPIXELS), 800'(img_exp(1)));
        s0 = start_cnt;
        repeat (5) tick();
        chk("t3_nostart", 800'(start_cnt - s0), 800'd0);
        iSNN_OUT = 2'b01;
        send_img(2, 1'b0);
        chk("t3_start", 800'(oSTART), 800'd1);
        chk("t3_pix2", 800'(oPIXELS), 800'(img_exp(2)));
        run_check(2'b01);

        // Reset in the middle of a run
        iSNN_OUT = 2'b10;
        send_img(0, 1'b0);
        repeat (3) tick();
        chk("t4_busy", 800'(oBUSY), 800'd1);
        iRESETn = 1'b0;
        #1;
        chk("t4_pix", 800'(oPIXELS), 800'd0);
        chk("t4_res", 800'(oRESULT), 800'd0);
        chk("t4_idx", 800'(oWORD_IDX), 800'd0);
        chk("t4_start", 800'(oSTART), 800'd0);
        chk("t4_rv", 800'(oRESULT_VALID), 800'd0);
        chk("t4_busy0", 800'(oBUSY), 800'd0);
        #2;
        iRESETn = 1'b1;
        tick();
        chk("t4_rdy", 800'(oREADY), 800'd1);

`ifdef IMAGE_LOADER_DBLBUF_EN
        // Second image loaded during the first run
        begin
            int found;
            send_img(0, 1'b0);
            chk("t5_start", 800'(oSTART), 800'd1);
            send_img(1, 1'b0);
            chk("t5_pend_rdy", 800'(oREADY), 800'd0);
            chk("t5_busy", 800'(oBUSY), 800'd1);
            chk("t5_pixA", 800'(oPIXELS), 800'({784{1'b1}}));
            found = 0;
            for (int i = 0; i < RUNC + 12 && found == 0; i++) begin
                if (oRESULT_VALID) found = 1;
                else tick();
            end
            chk("t5_rv", 800'(found), 800'd1);
            tick();
            chk("t5_start2", 800'(oSTART), 800'd1);
            chk("t5_pixB", 800'(oPIXELS), 800'(img_exp(1)));
            run_check(2'b10);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 784, the number of binary pixels per image.
REQ-002 SHALL have parameter WORD_W, default 32, the width of an input word.
REQ-003 SHALL have parameter RUN_CYCLES, default 1024, the number of network evaluation cycles per image.
REQ-004 SHALL have one clock and one reset: iCLK input 1, the single clock; iRESETn input 1, the reset, asynchronous and active-low.
REQ-005 SHALL have iWORD input WORD_W, a pixel word from the host bridge.
REQ-006 SHALL have iVALID input 1, indicating iWORD is valid.
REQ-007 SHALL have oREADY output 1, indicating the loader accepts iWORD.
REQ-008 SHALL have iABORT input 1, which discards a partial image or an in-flight run.
REQ-009 SHALL have oPIXELS output NUM_PIXELS, the image presented to the network.
REQ-010 SHALL have oSTART output 1, a one-cycle network start pulse.
REQ-011 SHALL have iSNN_OUT input 2, the network neuron outputs.
REQ-012 SHALL have oRESULT output 2, the captured classification.
REQ-013 SHALL have oRESULT_VALID output 1, a one-cycle result strobe.
REQ-014 SHALL have oBUSY output 1, high in states START, RUN and DONE.
REQ-015 SHALL have oWORD_IDX output 5, the index of the next word expected.

Function
REQ-016 SHALL set NWORDS = ceil(NUM_PIXELS/WORD_W), which is 25 by default.
REQ-017 SHALL transfer a word on a rising iCLK edge only when iVALID and oREADY are both high.
REQ-018 SHALL write word k bits [WORD_W-1:0] to internal buffer bits [WORD_W*k+WORD_W-1 : WORD_W*k]; for the last word, only the low NUM_PIXELS mod WORD_W bits (16 by default) are kept and the upper bits are discarded.
REQ-019 SHALL implement states IDLE, LOAD, START, RUN and DONE.
REQ-020 SHALL move from IDLE to LOAD on the first transfer, which sets oWORD_IDX to 1.
REQ-021 SHALL increment oWORD_IDX on each transfer in LOAD; the transfer of word NWORDS-1 moves the state to START and wraps oWORD_IDX to 0.
REQ-022 SHALL, on entering START, copy the buffer to oPIXELS and drive oSTART high for exactly one cycle, the cycle after the last transfer.
REQ-023 SHALL hold oPIXELS constant from START until the next START.
REQ-024 SHALL, in RUN, load a counter with RUN_CYCLES-1 and decrement it each cycle; the counter at 0 moves the state to DONE.
REQ-025 SHALL, in DONE, register iSNN_OUT into oRESULT, pulse oRESULT_VALID for one cycle, then go to IDLE.
REQ-026 SHALL hold oRESULT until the next DONE.
REQ-027 SHALL drive oREADY high in IDLE and LOAD only; other states depend on the configuration section.
REQ-028 SHALL, when iABORT is high in LOAD, return to IDLE and set oWORD_IDX to 0, with no change to oPIXELS; a transfer in the same cycle is dropped, so abort wins.
REQ-029 SHALL, when iABORT is high in START or RUN, return to IDLE with no oRESULT_VALID; oSTART, once issued, is not retracted.
REQ-030 SHALL ignore iABORT in IDLE and DONE.
REQ-031 SHALL NOT stall on iVALID gaps; oWORD_IDX holds while iVALID is low.

Reset
REQ-032 SHALL, on iRESETn low and asynchronously, set state=IDLE, oWORD_IDX=0, oPIXELS=0, oSTART=0, oRESULT=0, oRESULT_VALID=0, the counter to 0 and the buffer to 0.
REQ-033 SHALL treat reset mid-load or mid-run as discarding all data.
REQ-034 SHALL drive oREADY high in the first cycle after reset release.

Configuration
REQ-035 SHALL support macro IMAGE_LOADER_DBLBUF_EN.
REQ-036 SHALL, when IMAGE_LOADER_DBLBUF_EN is defined, keep oREADY high in START, RUN and DONE as well, so the next image loads during the run; a completed pending image enters START the cycle after DONE, skipping IDLE.
REQ-037 SHALL, when IMAGE_LOADER_DBLBUF_EN is defined, apply iABORT in RUN to the run only and preserve the pending load.
REQ-038 SHALL, when IMAGE_LOADER_DBLBUF_EN is undefined, hold oREADY low outside IDLE and LOAD.

Structure
REQ-039 SHALL take NWORDS, the state enum and the default widths from a shared package image_loader_pkg.
REQ-040 SHALL implement the word-addressed assembly register (write enable, word index, word data, last-word masking) as sub-module image_buf.

Verification
REQ-041 SHALL verify: 25 back-to-back words 0xFFFFFFFF -> oSTART one cycle after word 24; oPIXELS all ones (784 bits); bits 31:16 of word 24 dropped.
REQ-042 SHALL verify: word k = k, with iVALID toggling 50% -> oPIXELS[32k+31:32k] = k; oSTART fires once.
REQ-043 SHALL verify: RUN_CYCLES=8 with iSNN_OUT=2'b10 -> oRESULT_VALID 8 cycles after oSTART+1 with oRESULT=2'b10.
REQ-044 SHALL verify: iABORT together with word 10 -> oWORD_IDX=0 and no oSTART; next 25 words load cleanly.
REQ-045 SHALL verify: iRESETn low during RUN -> all outputs 0 immediately; oREADY=1 after release.
REQ-046 SHALL verify, with IMAGE_LOADER_DBLBUF_EN: second image loaded during RUN -> second oSTART exactly 1 cycle after first oRESULT_VALID; without the macro, oREADY=0 throughout RUN.
